// File: rtl/guitar_effect_pkg.sv
// guitar_effect register map, status bit positions and host-driver state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Shared by the host-side Avalon driver and the effect slave.
package guitar_effect_pkg;

  // Register addresses on the effect's Avalon-MM slave port
  localparam logic [4:0] ADDR_BYPASS = 5'd0;
  localparam logic [4:0] ADDR_GAIN   = 5'd1;
  localparam logic [4:0] ADDR_BOOST  = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_OUTPUT = 5'd5;
  localparam logic [4:0] ADDR_INPUT  = 5'd6;
  localparam logic [4:0] ADDR_RESET  = 5'd7;

  // STATUS register bits
  localparam int STAT_IN_ACK  = 4;  // last INPUT write was accepted
  localparam int STAT_OUT_VLD = 3;  // last OUTPUT read returned a valid sample

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_CFG0,
    S_CFG1,
    S_CFG2,
    S_WR_IN,
    S_ST_IN,
    S_RD_OUT,
    S_ST_OUT,
    S_PUSH
  } state_e;

endpackage

// File: rtl/guitar_effect_avl_driver.sv
// Avalon-MM master feeding samples into guitar_effect and collecting results; also programs
// bypass/gain/boost and issues soft resets. Latency: per sample >= 2 writes/reads, each read
// waits READ_LATENCY cycles. Backpressure: in_ready_o only when idle; out_valid_o holds until out_ready_i.
//
// Ports:
//   clk_i, reset_i                       clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i      upstream sample stream
//   out_valid_o/out_ready_i/out_data_o   processed sample stream
//   cfg_bypass_i/cfg_gain_i/cfg_boost_i  configuration values, latched on cfg_update_i
//   soft_reset_req_i                     request a write to the RESET register
//   busy_o, drop_count_o                 status: FSM not idle, saturating drop counter
//   avm_*                                Avalon-MM master (no waitrequest, fixed read latency)
module guitar_effect_avl_driver
  import guitar_effect_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int RETRY_MAX    = 4,
  parameter int POLL_MAX     = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  input  logic             cfg_bypass_i,
  input  logic [31:0]      cfg_gain_i,
  input  logic [31:0]      cfg_boost_i,
  input  logic             cfg_update_i,
  input  logic             soft_reset_req_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic [4:0]       avm_address_o,
  output logic             avm_write_o,
  output logic [31:0]      avm_writedata_o,
  output logic             avm_read_o,
  input  logic [31:0]      avm_readdata_i
);

  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [PW-1:0] POLL_LIM  = PW'(POLL_MAX);
  localparam logic [LW-1:0] LAT_INIT  = LW'(READ_LATENCY - 1);

  state_e           state_q, state_d;
  logic             rst_pend_q, rst_pend_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic             byp_q;
  logic [31:0]      gain_q, boost_q;
  logic [31:0]      sample_q, sample_d;
  logic [31:0]      out_q, out_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [PW-1:0]    poll_q, poll_d;
  logic             rd_pend_q, rd_pend_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             drop_inc;
  logic             rd_state;
  logic             rd_done;

  assign rd_state = (state_q == S_ST_IN) || (state_q == S_RD_OUT) || (state_q == S_ST_OUT);
  // Read issued and its data lands on avm_readdata_i this cycle
  assign rd_done  = rd_pend_q && (lat_q == '0);

  always_comb begin
    state_d         = state_q;
    rst_pend_d      = rst_pend_q;
    cfg_pend_d      = cfg_pend_q;
    sample_d        = sample_q;
    out_d           = out_q;
    retry_d         = retry_q;
    poll_d          = poll_q;
    rd_pend_d       = rd_pend_q;
    lat_d           = lat_q;
    drop_inc        = 1'b0;
    in_ready_o      = 1'b0;
    out_valid_o     = 1'b0;
    avm_address_o   = '0;
    avm_write_o     = 1'b0;
    avm_writedata_o = '0;
    avm_read_o      = 1'b0;

    // All read states share one strobe + countdown phase; the case below acts on rd_done only.
    if (rd_state) begin
      if (!rd_pend_q) begin
        avm_read_o    = 1'b1;
        avm_address_o = (state_q == S_RD_OUT) ? ADDR_OUTPUT : ADDR_STATUS;
        rd_pend_d     = 1'b1;
        lat_d         = LAT_INIT;
      end else if (!rd_done) begin
        lat_d = lat_q - LW'(1);
      end else begin
        rd_pend_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        in_ready_o = !rst_pend_q && !cfg_pend_q && !reset_i;
        if (rst_pend_q) begin
          rst_pend_d = 1'b0;
          state_d    = S_RST;
        end else if (cfg_pend_q) begin
          cfg_pend_d = 1'b0;
          state_d    = S_CFG0;
        end else if (in_valid_i) begin
          sample_d = in_data_i;
          retry_d  = '0;
          poll_d   = '0;
          state_d  = S_WR_IN;
        end
      end
      S_RST: begin
        avm_write_o     = 1'b1;
        avm_address_o   = ADDR_RESET;
        avm_writedata_o = 32'd1;
        state_d         = S_IDLE;
      end
      S_CFG0: begin
        avm_write_o     = 1'b1;
        avm_address_o   = ADDR_BYPASS;
        avm_writedata_o = {31'd0, byp_q};
        state_d         = S_CFG1;
      end
      S_CFG1: begin
        avm_write_o     = 1'b1;
        avm_address_o   = ADDR_GAIN;
        avm_writedata_o = gain_q;
        state_d         = S_CFG2;
      end
      S_CFG2: begin
        avm_write_o     = 1'b1;
        avm_address_o   = ADDR_BOOST;
        avm_writedata_o = boost_q;
        state_d         = S_IDLE;
      end
      S_WR_IN: begin
        avm_write_o     = 1'b1;
        avm_address_o   = ADDR_INPUT;
        avm_writedata_o = sample_q;
        retry_d         = retry_q + RW'(1);
        state_d         = S_ST_IN;
      end
      S_ST_IN: begin
        if (rd_done) begin
          if (avm_readdata_i[STAT_IN_ACK]) begin
            state_d = S_RD_OUT;
          end else if (retry_q < RETRY_LIM) begin
            state_d = S_WR_IN;
          end else begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_RD_OUT: begin
        if (rd_done) begin
          out_d   = avm_readdata_i;
          poll_d  = poll_q + PW'(1);
          state_d = S_ST_OUT;
        end
      end
      S_ST_OUT: begin
        if (rd_done) begin
          if (avm_readdata_i[STAT_OUT_VLD]) begin
            state_d = S_PUSH;
          end else if (poll_q < POLL_LIM) begin
            state_d = S_RD_OUT;
          end else begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_PUSH: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new request in the same cycle its flag is consumed must not be lost
    if (soft_reset_req_i) rst_pend_d = 1'b1;
    if (cfg_update_i)     cfg_pend_d = 1'b1;
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rst_pend_q <= 1'b0;
      cfg_pend_q <= 1'b0;
      byp_q      <= 1'b0;
      gain_q     <= '0;
      boost_q    <= '0;
      sample_q   <= '0;
      out_q      <= '0;
      retry_q    <= '0;
      poll_q     <= '0;
      rd_pend_q  <= 1'b0;
      lat_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      rst_pend_q <= rst_pend_d;
      cfg_pend_q <= cfg_pend_d;
      sample_q   <= sample_d;
      out_q      <= out_d;
      retry_q    <= retry_d;
      poll_q     <= poll_d;
      rd_pend_q  <= rd_pend_d;
      lat_q      <= lat_d;
      drop_q     <= drop_d;
      // Shadow the config so the three writes see one coherent snapshot
      if (cfg_update_i) begin
        byp_q   <= cfg_bypass_i;
        gain_q  <= cfg_gain_i;
        boost_q <= cfg_boost_i;
      end
    end
  end

  assign out_data_o   = out_q;
  assign busy_o       = (state_q != S_IDLE);
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_guitar_effect_avl_driver.sv
// Self-checking bench for guitar_effect_avl_driver: Avalon slave model with scripted
// STATUS responses, table-driven sample vectors, randomized samples against a
// behavioural model, and hand-written config / soft-reset / mid-transaction reset sequences.
module tb_guitar_effect_avl_driver;

  localparam int RL = 2;
  localparam int RM = 4;
  localparam int PM = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          cfg_bypass = 1'b0;
  logic [31:0]   cfg_gain = '0;
  logic [31:0]   cfg_boost = '0;
  logic          cfg_update = 1'b0;
  logic          soft_reset_req = 1'b0;
  logic          busy;
  logic [CW-1:0] drop_count;
  logic [4:0]    avm_address;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic          avm_read;
  logic [31:0]   avm_readdata = '0;

  guitar_effect_avl_driver #(
    .READ_LATENCY(RL), .RETRY_MAX(RM), .POLL_MAX(PM), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .cfg_bypass_i(cfg_bypass), .cfg_gain_i(cfg_gain), .cfg_boost_i(cfg_boost),
    .cfg_update_i(cfg_update), .soft_reset_req_i(soft_reset_req),
    .busy_o(busy), .drop_count_o(drop_count),
    .avm_address_o(avm_address), .avm_write_o(avm_write), .avm_writedata_o(avm_writedata),
    .avm_read_o(avm_read), .avm_readdata_i(avm_readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // ---------------- Avalon slave model ----------------
  int          cyc = 0;
  logic        phase_out = 1'b0;   // 0: after INPUT write, 1: after OUTPUT read
  int          st_in_reads = 0, st_out_reads = 0, rd5_cnt = 0, wr6_cnt = 0;
  int          in_fail_n = 0, out_fail_n = 0, bus_conflicts = 0;
  logic [31:0] out_base = '0, last_wr6 = '0;
  logic [4:0]  log_a[$];
  logic [31:0] log_d[$];
  logic        pend_vld = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_data = '0;

  // Read data appears only in its exact latency slot; every other cycle carries noise
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_vld && cyc == pend_due) begin
      avm_readdata = pend_data;
      pend_vld = 1'b0;
    end else begin
      avm_readdata = $urandom;
    end
  end

  always @(negedge clk) begin : slave
    logic [31:0] v;
    if (avm_write && avm_read) bus_conflicts++;
    if (avm_write) begin
      log_a.push_back(avm_address);
      log_d.push_back(avm_writedata);
      if (avm_address == 5'd6) begin
        wr6_cnt++;
        last_wr6 = avm_writedata;
        phase_out = 1'b0;
      end
    end
    if (avm_read) begin
      v = $urandom;
      if (avm_address == 5'd3) begin
        if (!phase_out) begin
          v[4] = (st_in_reads >= in_fail_n);
          st_in_reads++;
        end else begin
          v[3] = (st_out_reads >= out_fail_n);
          st_out_reads++;
        end
      end else if (avm_address == 5'd5) begin
        v = out_base + 32'(rd5_cnt) * 32'h111;
        rd5_cnt++;
        phase_out = 1'b1;
      end
      pend_vld  = 1'b1;
      pend_due  = cyc + RL;
      pend_data = v;
    end
  end

  // ---------------- sample driver ----------------
  task automatic run_sample(input logic [31:0] d, input int inf, input int outf,
                            input logic [31:0] base, input int cfg_at,
                            output logic got_out, output logic [31:0] got_data,
                            output logic stable_ok, output logic done);
    int n, hold, k;
    got_out = 1'b0; got_data = '0; stable_ok = 1'b1; done = 1'b0;
    in_fail_n = inf; out_fail_n = outf; out_base = base;
    st_in_reads = 0; st_out_reads = 0; rd5_cnt = 0; wr6_cnt = 0; phase_out = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) return;
    in_valid = 1'b1; in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = $urandom;
    hold = $urandom_range(0, 3);
    k = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cfg_update = (i == cfg_at);
      if (out_valid) begin
        if (!got_out) begin
          got_out  = 1'b1;
          got_data = out_data;
        end else if (out_data !== got_data) begin
          stable_ok = 1'b0;
        end
        out_ready = (k >= hold);
        k++;
      end else begin
        out_ready = 1'b0;
        if (!busy) begin
          done = 1'b1;
          break;
        end
      end
    end
    cfg_update = 1'b0;
    out_ready  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] din;
    int          inf;
    int          outf;
    logic [31:0] base;
    logic        exp_vld;
    logic [31:0] exp_dat;
    int          exp_wr6;
    int          exp_rd5;
    logic        exp_drop;
  } vec_t;

  int model_drops = 0;

  task automatic run_vec(input vec_t v);
    logic go, st, dn;
    logic [31:0] gd;
    run_sample(v.din, v.inf, v.outf, v.base, -1, go, gd, st, dn);
    if (v.exp_drop && model_drops < (1 << CW) - 1) model_drops++;
    chk("sample_done", 32'(dn), 32'd1);
    chk("out_valid_seen", 32'(go), 32'(v.exp_vld));
    if (v.exp_vld) begin
      chk("out_data", gd, v.exp_dat);
      chk("out_stable", 32'(st), 32'd1);
    end
    chk("wr_input_count", 32'(wr6_cnt), 32'(v.exp_wr6));
    chk("wr_input_data", last_wr6, v.din);
    chk("rd_output_count", 32'(rd5_cnt), 32'(v.exp_rd5));
    chk("drop_count", 32'(drop_count), 32'(model_drops));
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  // Reference: outcome computed from the retry/poll rules directly
  function automatic vec_t model(input logic [31:0] din, input int inf, input int outf,
                                 input logic [31:0] base);
    vec_t r;
    r.din = din; r.inf = inf; r.outf = outf; r.base = base;
    r.exp_wr6 = (inf >= RM) ? RM : inf + 1;
    r.exp_rd5 = 0; r.exp_vld = 1'b0; r.exp_dat = '0; r.exp_drop = 1'b1;
    if (inf < RM) begin
      r.exp_rd5 = (outf >= PM) ? PM : outf + 1;
      if (outf < PM) begin
        r.exp_vld  = 1'b1;
        r.exp_drop = 1'b0;
        r.exp_dat  = base + 32'(outf) * 32'h111;
      end
    end
    return r;
  endfunction

  vec_t tbl[6];

  initial begin
    logic go, st, dn;
    logic [31:0] gd;
    logic found;

    tbl[0] = '{32'h0000_1234, 0,    0, 32'h0000_2468, 1'b1, 32'h0000_2468, 1, 1, 1'b0};
    tbl[1] = '{32'h0000_0ABC, 1000, 0, 32'h0000_0000, 1'b0, 32'h0,         4, 0, 1'b1};
    tbl[2] = '{32'hCAFE_0001, 0,    3, 32'h0000_1000, 1'b1, 32'h0000_1333, 1, 4, 1'b0};
    tbl[3] = '{32'h1111_2222, 3,    7, 32'h0000_5000, 1'b1, 32'h0000_5777, 4, 8, 1'b0};
    tbl[4] = '{32'h3333_4444, 0,    8, 32'h0000_0000, 1'b0, 32'h0,         1, 8, 1'b1};
    tbl[5] = '{32'h5555_6666, 4,    0, 32'h0000_0000, 1'b0, 32'h0,         4, 0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    foreach (tbl[i]) run_vec(tbl[i]);

    // Randomized samples against the model
    for (int i = 0; i < 20; i++) begin
      run_vec(model($urandom, $urandom_range(0, 5), $urandom_range(0, 9),
                    $urandom & 32'h00FF_FFFF));
    end

    // cfg_update pulsed mid-sample: serviced only after the sample completes
    cfg_bypass = 1'b1; cfg_gain = 32'h10; cfg_boost = 32'h3;
    log_a.delete(); log_d.delete();
    run_sample(32'h0000_7777, 0, 2, 32'h0000_0100, 3, go, gd, st, dn);
    chk("cfg_mid_done", 32'(dn), 32'd1);
    chk("cfg_mid_out_data", gd, 32'h0000_0322);
    repeat (10) @(negedge clk);
    chk("cfg_mid_nwrites", 32'(log_a.size()), 32'd4);
    if (log_a.size() == 4) begin
      chk("cfg_mid_w0_addr", 32'(log_a[0]), 32'd6);
      chk("cfg_mid_w1_addr", 32'(log_a[1]), 32'd0);
      chk("cfg_mid_w1_data", log_d[1], 32'd1);
      chk("cfg_mid_w2_addr", 32'(log_a[2]), 32'd1);
      chk("cfg_mid_w2_data", log_d[2], 32'h10);
      chk("cfg_mid_w3_addr", 32'(log_a[3]), 32'd2);
      chk("cfg_mid_w3_data", log_d[3], 32'h3);
    end

    // soft reset and cfg in the same cycle: RESET write goes first
    log_a.delete(); log_d.delete();
    cfg_bypass = 1'b0; cfg_gain = 32'h22; cfg_boost = 32'h7;
    soft_reset_req = 1'b1; cfg_update = 1'b1;
    @(negedge clk);
    soft_reset_req = 1'b0; cfg_update = 1'b0;
    repeat (10) @(negedge clk);
    chk("both_nwrites", 32'(log_a.size()), 32'd4);
    if (log_a.size() == 4) begin
      chk("both_w0_addr", 32'(log_a[0]), 32'd7);
      chk("both_w0_data", log_d[0], 32'd1);
      chk("both_w1_addr", 32'(log_a[1]), 32'd0);
      chk("both_w1_data", log_d[1], 32'd0);
      chk("both_w2_data", log_d[2], 32'h22);
      chk("both_w3_addr", 32'(log_a[3]), 32'd2);
      chk("both_w3_data", log_d[3], 32'h7);
    end
    chk("both_idle", 32'(busy), 32'd0);

    // reset while polling OUTPUT status
    in_fail_n = 0; out_fail_n = 1000; out_base = 32'hABCD;
    st_in_reads = 0; st_out_reads = 0; rd5_cnt = 0; phase_out = 1'b0;
    in_valid = 1'b1; in_data = 32'h9999;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avm_read && avm_address == 5'd3 && phase_out) begin
        found = 1'b1;
        break;
      end
    end
    chk("found_st_out", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_read", 32'(avm_read), 32'd0);
    chk("midrst_write", 32'(avm_write), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;
    model_drops = 0;
    repeat (3) @(negedge clk);
    chk("after_rst_busy", 32'(busy), 32'd0);
    chk("after_rst_in_ready", 32'(in_ready), 32'd1);

    // Saturation of the drop counter
    for (int i = 0; i < (1 << CW) + 1; i++) run_vec(model(32'(i), 1000, 0, 32'h0));
    chk("drop_saturated", 32'(drop_count), 32'((1 << CW) - 1));

    chk("bus_conflicts", 32'(bus_conflicts), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
